// File: rtl/disc_write_fetcher_if.sv
// SRAM read-port bundle between the write-side fetcher (master) and the
// acquisition SRAM arbiter/memory (slave).
interface disc_write_fetcher_if #(
  parameter int ADDR_WIDTH = 19
);
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic                  sram_rd;
  logic                  sram_grant;
  logic [7:0]            sram_data;

  modport master (output sram_addr, sram_rd, input sram_grant, sram_data);
  modport slave  (input sram_addr, sram_rd, output sram_grant, sram_data);
endinterface

// File: rtl/disc_write_fetcher.sv
// Write-side SRAM prefetcher: streams pattern bytes into a small FIFO and
// hands them to the disc writer one byte per maddr_inc strobe.
module disc_write_fetcher #(
  parameter int ADDR_WIDTH  = 19,
  parameter int DEPTH_LOG2  = 2,
  parameter int RAM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  run,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  disc_write_fetcher_if.master  sram,
  output logic [7:0]            mdat,
  input  logic                  maddr_inc,
  output logic                  ready,
  output logic                  empty,
  output logic                  underrun,
  input  logic                  clear_underrun,
  output logic [ADDR_WIDTH-1:0] fetch_addr
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_e;

  state_e                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        ptr_q, ptr_d, addr_q;
  logic [RAM_LATENCY:0]         vld_pipe_q, vld_pipe_d;
  logic [DEPTH-1:0][7:0]        mem_q;
  logic [DEPTH_LOG2-1:0]        wp_q, rp_q;
  logic [CW-1:0]                count_q, count_d;
  logic                         empty_q, underrun_q;
  logic                         flush, issue, push, pop, pop_empty;
  logic [15:0]                  occ;

  // Occupancy seen by the issue logic: FIFO after this cycle's pop plus
  // every read still travelling through the SRAM pipe (bit 0 = strobe on bus).
  always_comb begin
    occ = 16'(count_q) - 16'(pop);
    for (int i = 0; i <= RAM_LATENCY; i++) occ = occ + 16'(vld_pipe_q[i]);
  end

  always_comb begin
    flush     = addr_load || !run;
    pop       = clken && maddr_inc && (count_q != '0);
    pop_empty = clken && maddr_inc && (count_q == '0);
    push      = vld_pipe_q[RAM_LATENCY] && !flush && (state_q != IDLE);
    issue     = !flush && clken && sram.sram_grant && (state_q != IDLE) &&
                (occ < 16'(DEPTH));

    count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
    vld_pipe_d = flush ? '0 : {vld_pipe_q[RAM_LATENCY-1:0], issue};
    ptr_d      = addr_load ? addr_in : ptr_q + ADDR_WIDTH'(issue);

    state_d = state_q;
    if (addr_load)   state_d = run ? PRIME : IDLE;
    else if (!run)   state_d = IDLE;
    else if (clken) begin
      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (count_d == CW'(DEPTH)) state_d = STREAM;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      addr_q     <= '0;
      vld_pipe_q <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      underrun_q <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      vld_pipe_q <= vld_pipe_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      if (issue) addr_q <= ptr_q;
      if (pop_empty)           underrun_q <= 1'b1;
      else if (clear_underrun) underrun_q <= 1'b0;
      if (flush) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wp_q] <= sram.sram_data;
  end

  // The issue budget guarantees a free slot for every returning read.
  always_ff @(posedge clock) begin
    if (reset) assert (!(push && !pop && count_q == CW'(DEPTH)));
  end

  assign sram.sram_rd   = vld_pipe_q[0];
  assign sram.sram_addr = addr_q;
  assign mdat           = empty_q ? 8'h00 : mem_q[rp_q];
  assign empty          = empty_q;
  assign ready          = (state_q == STREAM);
  assign underrun       = underrun_q;
  assign fetch_addr     = ptr_q;
endmodule

// File: doc/disc_write_fetcher.md
Name: disc_write_fetcher

Overview:
- Upstream feeder for the disc writer.
- Streams write-pattern bytes from the external acquisition SRAM into a small prefetch FIFO.
- Presents the FIFO head on mdat and pops one byte per maddr_inc strobe from the writer.
- Owns the write-side SRAM read pointer, read pipeline, prime/underrun status and flush-on-stop behaviour.

Parameters:
ADDR_WIDTH, 19, SRAM address width in bytes; the pointer wraps modulo 2^ADDR_WIDTH
DEPTH_LOG2, 2, prefetch FIFO depth = 2^DEPTH_LOG2 entries
RAM_LATENCY, 2, clocks from sram_rd asserted to sram_data valid (min 1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
clken  in  1  clock enable; gates read issue and pops only
run  in  1  fetch enable; level-sensitive
addr_load  in  1  load pointer from addr_in; flushes buffer
addr_in  in  ADDR_WIDTH  start address
sram_grant  in  1  SRAM arbiter grant for this port
sram_addr  out  ADDR_WIDTH  SRAM read address
sram_rd  out  1  SRAM read strobe, one byte per cycle asserted
sram_data  in  8  SRAM read data
mdat  out  8  FIFO head byte to the writer
maddr_inc  in  1  pop strobe from the writer
ready  out  1  buffer primed; writer may be started
empty  out  1  FIFO holds no bytes
underrun  out  1  sticky: pop while empty
clear_underrun  in  1  clears underrun
fetch_addr  out  ADDR_WIDTH  next address to be issued (status)

Behaviour:
- Reset (reset=0, async) values:
  - FSM=IDLE; pointer=0; FIFO count=0; pipeline valid bits=0.
  - sram_rd=0, sram_addr=0, mdat=8'h00, ready=0, empty=1, underrun=0.
- FSM states: IDLE, PRIME, STREAM.
  - IDLE: no reads issued; FIFO and in-flight reads discarded. run=1 -> PRIME.
  - PRIME: issue reads; ready=0. When the FIFO reaches full (count = 2^DEPTH_LOG2) -> STREAM.
  - STREAM: ready=1. Keep refilling; ready stays 1 even if the FIFO drains.
  - Any state with run=0 -> IDLE on the next clock. Flush: count:=0, pipeline valids cleared, ready:=0. Pointer is retained.
- Read issue, in PRIME/STREAM:
  - sram_rd=1 in a cycle when clken=1, sram_grant=1 and (count + inflight) < 2^DEPTH_LOG2.
  - sram_addr = pointer, registered; the pointer increments after each issue.
  - 2^ADDR_WIDTH-1 wraps to 0.
- Return path:
  - A RAM_LATENCY-deep valid shift register runs every clock, independent of clken.
  - Data is captured into the FIFO tail when the valid bit emerges.
  - Overflow is impossible by construction. Any push into a full FIFO is a design error; assert in simulation.
- Pop:
  - maddr_inc=1 and clken=1 with count>0: head advances next clock.
  - mdat is the registered head value; the new head is visible one clock after the pop.
  - With count=0, mdat=8'h00.
- Simultaneous push and pop: count unchanged; data order preserved.
- Pop while empty, in any state with clken=1:
  - underrun:=1; count stays 0; mdat=8'h00.
  - underrun stays set until clear_underrun=1 or reset. If set and clear coincide, set wins.
- addr_load=1, highest priority:
  - pointer := addr_in.
  - FIFO and in-flight reads flushed; ready := 0.
  - If run=1, FSM -> PRIME; otherwise -> IDLE.
  - No read is issued in the load cycle.
- clken=0: no issue, no pop, no FSM transition except the run=0 and addr_load flushes. In-flight data still lands in the FIFO.
- empty = (count==0), registered together with count.
- Reset mid-stream: all state returns immediately to the reset values above; no SRAM strobe after reset assertion.

Test Plan:
1. Reset; RAM[i]=i&0xFF; addr_load addr_in=0x10; run=1, grant=1, no pops.
   -> exactly 4 sram_rd pulses (addresses 0x10..0x13); ready=1 within 4+RAM_LATENCY+1 clocks; mdat=0x10.
2. Continue from 1, maddr_inc every cycle for 100 cycles.
   -> popped sequence 0x10,0x11,...,0x73 contiguous; underrun=0; fetch_addr advances by one per read.
3. addr_load addr_in=0x7FFFE, run, pop 4.
   -> bytes from addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001; no skipped or duplicated byte.
4. Prime, then hold sram_grant=0 and pop 5 times.
   -> first 4 pops return data; 5th sets underrun=1 with mdat=0x00. clear_underrun -> underrun=0.
5. Mid-stream drop run for 1 clock with 2 reads in flight.
   -> ready=0, empty=1, in-flight data discarded. Re-run resumes at retained fetch_addr with no stale byte.
6. Assert reset while sram_rd=1 and count=3.
   -> sram_rd=0, ready=0, empty=1, mdat=0x00 immediately; no further reads until run and a new addr_load.
